// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave front end.
//   state_e      : controller states
//   CMD_*        : command codes carried in frame bits [9:8]; passed through
//                  to the RAM unchecked, the RAM does the decode
//   *_DEF        : default widths used by the parameterised modules
// ----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// ----------------------------------------------------------------------------
// spi_tx_serializer
// Parallel-to-serial converter for the MISO response. A load strobe captures
// a DATA_W word; the following DATA_W cycles present it MSB first on miso.
// miso is 0 whenever no word is being shifted out.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (slave-select abort), wins over load
//   load       : capture data and start shifting
//   data       : word to transmit
//   miso       : serial output
//   done       : high during the cycle the last bit is on miso
// ----------------------------------------------------------------------------
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bits_left;
    logic              active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bits_left <= '0;
            active    <= 1'b0;
        end else if (clr) begin
            shreg     <= '0;
            bits_left <= '0;
            active    <= 1'b0;
        end else if (load) begin
            shreg     <= data;
            bits_left <= CW'(DATA_W - 1);
            active    <= 1'b1;
        end else if (active) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            if (bits_left == '0) begin
                active <= 1'b0;
            end else begin
                bits_left <= bits_left - 1'b1;
            end
        end
    end

    assign miso = active & shreg[DATA_W-1];
    assign done = active & (bits_left == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// ----------------------------------------------------------------------------
// spi_slave_ctrl
// SPI slave front end: deserialises MOSI frames (2 command + 8 payload bits,
// MSB first) into rx_data with a one-cycle rx_valid strobe, and after a
// read-data frame serialises the RAM's tx_data on MISO, MSB first.
// Ports:
//   clk      : SPI clock, everything samples on the rising edge
//   rst_n    : async active-low reset
//   SS_n     : slave select, active low; high aborts any transfer
//   MOSI     : serial data in
//   MISO     : serial data out, 0 unless a response is being shifted
//   rx_data  : last completed frame, held until the next one completes
//   rx_valid : one-cycle strobe, the cycle after the 10th sampled bit
//   tx_data  : read data from the RAM
//   tx_valid : tx_data strobe, only honoured while a read-data frame waits
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | slave not selected
// CHK_CMD   | sample frame bit 9, pick write / read-address / read-data
// WRITE     | shift in bits 8..0 of a write frame, then ignore MOSI
// READ_ADD  | shift in a read-address frame; completion sets rd_addr_seen
// READ_DATA | shift in frame, wait for tx_valid, shift response on MISO
// ----------------------------------------------------------------------------
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] rx_shift;
    logic               frame_done;
    logic               tx_loaded;
    logic               rd_addr_seen;
    logic               abort;
    logic               ser_load;
    logic               ser_done;

    assign abort = SS_n && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              state_nxt = IDLE;
                else if (!MOSI)        state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            WRITE, READ_ADD: begin
                if (SS_n) state_nxt = IDLE;
            end
            READ_DATA: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end else if (frame_done && !tx_loaded && tx_valid) begin
                    ser_load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. Abort has priority so a frame or response cut short by SS_n
    // never produces rx_valid; rd_addr_seen deliberately survives aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            tx_loaded    <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_loaded  <= 1'b0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        rx_shift   <= {rx_shift[FRAME_W-3:0], MOSI};
                        bit_cnt    <= CNT_W'(1);
                        frame_done <= 1'b0;
                        tx_loaded  <= 1'b0;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
                            if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                                rx_data    <= {rx_shift, MOSI};
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                bit_cnt    <= '0;
                                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (ser_load) tx_loaded <= 1'b1;
                // A read-data transaction counts as complete once its last
                // response bit has been driven.
                if (state == READ_DATA && ser_done) rd_addr_seen <= 1'b0;
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .load  (ser_load),
        .data  (tx_data),
        .miso  (MISO),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: which read state a frame lands in, and the last frame.
    logic       m_seen;
    logic [9:0] m_rx_data;

    spi_slave_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, ERRORS %0d", errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 = write, 1 = read address, 2 = read data, decided from command bits
    // and whether a read address is pending.
    function automatic int frame_kind(input logic [9:0] f, input logic seen);
        if (f[9:8] == CMD_WR_ADDR || f[9:8] == CMD_WR_DATA) return 0;
        return seen ? 2 : 1;
    endfunction

    // Select, clock in a full frame, and report the rx_valid pulse shape.
    task automatic run_frame(input logic [9:0] f, output logic pre_v, output logic v,
                             output logic [9:0] d, output logic post_v);
        pre_v = 1'b0;
        SS_n  = 1'b0;
        MOSI  = f[9];
        step();
        pre_v |= rx_valid;
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            step();
            if (i > 0) pre_v |= rx_valid;
        end
        v    = rx_valid;
        d    = rx_data;
        MOSI = 1'($urandom);
        step();
        post_v = rx_valid;
    endtask

    // Offer a tx_valid word after dly idle cycles and capture 8 MISO bits.
    task automatic run_response(input logic [7:0] dv, input int dly,
                                output logic [7:0] bits, output logic quiet);
        quiet = (MISO === 1'b0);
        repeat (dly) begin
            MOSI = 1'($urandom);
            step();
            if (MISO !== 1'b0) quiet = 1'b0;
        end
        tx_valid = 1'b1;
        tx_data  = dv;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
            bits[i] = MISO;
            step();
        end
        if (MISO !== 1'b0) quiet = 1'b0;
        tx_valid = 1'b1;
        repeat (2) begin
            step();
            if (MISO !== 1'b0) quiet = 1'b0;
        end
        tx_valid = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'($urandom);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #23;
        checks++;
        if ({MISO, rx_valid, rx_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset outputs got MISO=%b rx_valid=%b rx_data=%h want 0/0/000",
                     MISO, rx_valid, rx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_seen = 1'b0;
        m_rx_data = 10'h000;
        step();
    endtask

    task automatic test_write_addr();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        run_frame(10'h0A5, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010) begin
            errors++;
            $display("FAIL wr_addr rx_valid pulse got %b want 010", {pre_v, v, post_v});
        end
        checks++;
        if (d !== 10'h0A5) begin
            errors++;
            $display("FAIL wr_addr rx_data got %h want 0a5", d);
        end
        m_rx_data = 10'h0A5;
        run_response(8'h5A, 1, bits, q);
        checks++;
        if (bits !== 8'h00 || q !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr miso got %h quiet=%b want 00 quiet=1", bits, q);
        end
        end_frame();
    endtask

    task automatic test_read_sequence();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        run_frame(10'h207, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h207) begin
            errors++;
            $display("FAIL rd_addr frame got pulse=%b data=%h want 010/207", {pre_v, v, post_v}, d);
        end
        run_response(8'hA7, 0, bits, q);
        checks++;
        if (bits !== 8'h00 || q !== 1'b1) begin
            errors++;
            $display("FAIL rd_addr miso got %h quiet=%b want 00 quiet=1", bits, q);
        end
        m_seen = 1'b1;
        end_frame();
        run_frame(10'h300, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h300) begin
            errors++;
            $display("FAIL rd_data frame got pulse=%b data=%h want 010/300", {pre_v, v, post_v}, d);
        end
        run_response(8'hC3, 2, bits, q);
        checks++;
        if (bits !== 8'hC3 || q !== 1'b1) begin
            errors++;
            $display("FAIL rd_data miso got %h quiet=%b want c3 quiet=1", bits, q);
        end
        m_seen = 1'b0;
        m_rx_data = 10'h300;
        end_frame();
    endtask

    task automatic test_second_read();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        run_frame(10'h3F1, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h3F1) begin
            errors++;
            $display("FAIL second_read frame got pulse=%b data=%h want 010/3f1", {pre_v, v, post_v}, d);
        end
        run_response(8'hFF, 1, bits, q);
        checks++;
        if (bits !== 8'h00 || q !== 1'b1) begin
            errors++;
            $display("FAIL second_read miso got %h quiet=%b want 00 quiet=1 (read-address)", bits, q);
        end
        m_seen = 1'b1;
        m_rx_data = 10'h3F1;
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        logic [9:0] f;
        f = 10'h2B4;
        SS_n = 1'b0;
        step();
        for (int i = 9; i >= 5; i--) begin
            MOSI = f[i];
            step();
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({MISO, rx_valid, rx_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid outputs got MISO=%b rx_valid=%b rx_data=%h want 0/0/000",
                     MISO, rx_valid, rx_data);
        end
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        m_seen = 1'b0;
        m_rx_data = 10'h000;
        step();
        run_frame(10'h2C3, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h2C3) begin
            errors++;
            $display("FAIL reset_mid frame got pulse=%b data=%h want 010/2c3", {pre_v, v, post_v}, d);
        end
        run_response(8'h81, 0, bits, q);
        checks++;
        if (bits !== 8'h00 || q !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid miso got %h quiet=%b want 00 quiet=1", bits, q);
        end
        m_seen = 1'b1;
        m_rx_data = 10'h2C3;
        end_frame();
    endtask

    task automatic test_aborted_read_data();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        run_frame(10'h355, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h355) begin
            errors++;
            $display("FAIL abort_rd frame got pulse=%b data=%h want 010/355", {pre_v, v, post_v}, d);
        end
        m_rx_data = 10'h355;
        SS_n = 1'b1;
        q = 1'b1;
        step();
        if (MISO !== 1'b0) q = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        repeat (9) begin
            step();
            if (MISO !== 1'b0) q = 1'b0;
        end
        tx_valid = 1'b0;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd miso got activity want 0");
        end
        run_frame(10'h3AA, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h3AA) begin
            errors++;
            $display("FAIL abort_rd next frame got pulse=%b data=%h want 010/3aa", {pre_v, v, post_v}, d);
        end
        run_response(8'h96, 3, bits, q);
        checks++;
        if (bits !== 8'h96 || q !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd next miso got %h quiet=%b want 96 quiet=1", bits, q);
        end
        m_seen = 1'b0;
        m_rx_data = 10'h3AA;
        end_frame();
    endtask

    task automatic test_abort();
        logic pre_v, v, post_v, anyv;
        logic [9:0] d;
        logic [9:0] f;
        f = 10'h1F0;
        anyv = 1'b0;
        SS_n = 1'b0;
        step();
        for (int i = 9; i >= 4; i--) begin
            MOSI = f[i];
            step();
            anyv |= rx_valid;
        end
        SS_n = 1'b1;
        step();
        anyv |= rx_valid;
        step();
        anyv |= rx_valid;
        checks++;
        if (anyv !== 1'b0 || rx_data !== m_rx_data) begin
            errors++;
            $display("FAIL abort6 got rx_valid=%b rx_data=%h want 0/%h", anyv, rx_data, m_rx_data);
        end
        run_frame(10'h0C6, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h0C6) begin
            errors++;
            $display("FAIL abort6 next frame got pulse=%b data=%h want 010/0c6", {pre_v, v, post_v}, d);
        end
        m_rx_data = 10'h0C6;
        end_frame();
    endtask

    task automatic test_abort_last_bit();
        logic [9:0] f;
        logic anyv;
        f = 10'h1E7;
        anyv = 1'b0;
        SS_n = 1'b0;
        step();
        for (int i = 9; i >= 1; i--) begin
            MOSI = f[i];
            step();
            anyv |= rx_valid;
        end
        MOSI = f[0];
        SS_n = 1'b1;
        step();
        anyv |= rx_valid;
        step();
        anyv |= rx_valid;
        checks++;
        if (anyv !== 1'b0 || rx_data !== m_rx_data) begin
            errors++;
            $display("FAIL abort_last got rx_valid=%b rx_data=%h want 0/%h", anyv, rx_data, m_rx_data);
        end
    endtask

    task automatic test_abort_with_tx_valid();
        logic pre_v, v, post_v, q;
        logic [9:0] d;
        logic [7:0] bits;
        run_frame(10'h211, pre_v, v, d, post_v);
        end_frame();
        m_seen = 1'b1;
        run_frame(10'h3EE, pre_v, v, d, post_v);
        checks++;
        if ({pre_v, v, post_v} !== 3'b010 || d !== 10'h3EE) begin
            errors++;
            $display("FAIL abort_tx frame got pulse=%b data=%h want 010/3ee", {pre_v, v, post_v}, d);
        end
        m_rx_data = 10'h3EE;
        SS_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        step();
        tx_valid = 1'b0;
        q = (MISO === 1'b0);
        repeat (9) begin
            step();
            if (MISO !== 1'b0) q = 1'b0;
        end
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL abort_tx miso got activity want 0");
        end
        run_frame(10'h300, pre_v, v, d, post_v);
        run_response(8'h3C, 1, bits, q);
        checks++;
        if (bits !== 8'h3C || q !== 1'b1 || d !== 10'h300) begin
            errors++;
            $display("FAIL abort_tx next miso got %h quiet=%b data=%h want 3c quiet=1 data=300",
                     bits, q, d);
        end
        m_seen = 1'b0;
        m_rx_data = 10'h300;
        end_frame();
    endtask

    task automatic test_random();
        logic pre_v, v, post_v, q, anyv;
        logic [9:0] d, f;
        logic [7:0] bits, dv, exp_bits;
        int kind, cut, dly;
        for (int n = 0; n < 24; n++) begin
            f = 10'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cut = $urandom_range(1, 9);
                anyv = 1'b0;
                SS_n = 1'b0;
                step();
                for (int k = 0; k < cut; k++) begin
                    MOSI = f[9-k];
                    step();
                    anyv |= rx_valid;
                end
                SS_n = 1'b1;
                step();
                anyv |= rx_valid;
                step();
                anyv |= rx_valid;
                checks++;
                if (anyv !== 1'b0 || rx_data !== m_rx_data) begin
                    errors++;
                    $display("FAIL rand%0d abort after %0d got rx_valid=%b rx_data=%h want 0/%h",
                             n, cut, anyv, rx_data, m_rx_data);
                end
            end else begin
                kind = frame_kind(f, m_seen);
                run_frame(f, pre_v, v, d, post_v);
                checks++;
                if ({pre_v, v, post_v} !== 3'b010 || d !== f) begin
                    errors++;
                    $display("FAIL rand%0d frame got pulse=%b data=%h want 010/%h",
                             n, {pre_v, v, post_v}, d, f);
                end
                m_rx_data = f;
                dv  = 8'($urandom);
                dly = $urandom_range(0, 3);
                run_response(dv, dly, bits, q);
                exp_bits = (kind == 2) ? dv : 8'h00;
                checks++;
                if (bits !== exp_bits || q !== 1'b1) begin
                    errors++;
                    $display("FAIL rand%0d miso kind=%0d got %h quiet=%b want %h quiet=1",
                             n, kind, bits, q, exp_bits);
                end
                if (kind == 1) m_seen = 1'b1;
                if (kind == 2) m_seen = 1'b0;
                end_frame();
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_sequence();
        test_second_read();
        test_reset_mid_frame();
        test_aborted_read_data();
        test_abort();
        test_abort_last_bit();
        test_abort_with_tx_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
